// File: rtl/mem_arbiter_pkg.sv
// Shared constants and helpers for the two-requester memory arbiter.
// `CLOG2 lives here so every file that includes this package sees the same macro.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package mem_arbiter_pkg;

    localparam int NREQ = 2;

    // Round-robin pick: a lone requester always wins; on contention the pointer decides.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] req, input logic ptr);
        rr_pick = req;
        if (&req) rr_pick = ptr ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: per-requester read and write channels.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = 6
);
    logic [NREQ-1:0]       rd_req;
    logic [NREQ*AW-1:0]    rd_addr;
    logic [NREQ-1:0]       rd_gnt;
    logic [NREQ-1:0]       rd_valid;
    logic [WIDTH-1:0]      rd_data;
    logic [NREQ-1:0]       wr_req;
    logic [NREQ*AW-1:0]    wr_addr;
    logic [NREQ*WIDTH-1:0] wr_data;
    logic [NREQ-1:0]       wr_gnt;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_gnt, rd_valid, rd_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_gnt, rd_valid, rd_data, wr_gnt
    );
endinterface

// File: rtl/mem_arbiter_mem.sv
// Simple dual-port synchronous RAM: one read and one write port, read-before-write
// on an address collision.
module mem_arbiter_mem
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter     FILE  = "",
    parameter int INIT  = 0,
    parameter int AW    = `CLOG2(DEPTH)
) (
    input  logic             clock,
    input  logic             rden,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    input  logic             wren,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata
);
    logic [WIDTH-1:0] ram [DEPTH];

    always_ff @(posedge clock) begin
        if (rden) rdata <= ram[raddr];
        if (wren) ram[waddr] <= wdata;
    end
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single dual-port RAM.
// Define MEM_ARB_BYPASS_EN to forward same-cycle same-address write data to the reader.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter     FILE  = ""
) (
    input logic           clock,
    input logic           reset,
    mem_arbiter_if.slave  bus
);
    localparam int AW = `CLOG2(DEPTH);

    logic             rd_ptr, wr_ptr;
    logic             rden, wren;
    logic [AW-1:0]    raddr, waddr;
    logic [WIDTH-1:0] wdata, mem_q;

    // Grants are masked during reset so the RAM sees neither port active.
    always_comb begin
        bus.rd_gnt = '0;
        bus.wr_gnt = '0;
        if (!reset) begin
            bus.rd_gnt = rr_pick(bus.rd_req, rd_ptr);
            bus.wr_gnt = rr_pick(bus.wr_req, wr_ptr);
        end
    end

    assign rden  = |bus.rd_gnt;
    assign wren  = |bus.wr_gnt;
    assign raddr = bus.rd_gnt[1] ? bus.rd_addr[AW +: AW]    : bus.rd_addr[0 +: AW];
    assign waddr = bus.wr_gnt[1] ? bus.wr_addr[AW +: AW]    : bus.wr_addr[0 +: AW];
    assign wdata = bus.wr_gnt[1] ? bus.wr_data[WIDTH +: WIDTH] : bus.wr_data[0 +: WIDTH];

    // After a grant the pointer names the other requester: granting 0 prefers 1 next.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            bus.rd_valid <= '0;
        end else begin
            bus.rd_valid <= bus.rd_gnt;
            if (rden) rd_ptr <= bus.rd_gnt[0];
            if (wren) wr_ptr <= bus.wr_gnt[0];
        end
    end

    mem_arbiter_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .FILE  (FILE),
        .INIT  (0)
    ) u_mem (
        .clock (clock),
        .rden  (rden),
        .raddr (raddr),
        .rdata (mem_q),
        .wren  (wren),
        .waddr (waddr),
        .wdata (wdata)
    );

`ifdef MEM_ARB_BYPASS_EN
    logic             byp_vld;
    logic [WIDTH-1:0] byp_data;

    always_ff @(posedge clock) begin
        if (reset) byp_vld <= 1'b0;
        else       byp_vld <= rden & wren & (raddr == waddr);
        byp_data <= wdata;
    end

    assign bus.rd_data = byp_vld ? byp_data : mem_q;
`else
    assign bus.rd_data = mem_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised plus directed bench for mem_arbiter against a queue-free array model.
module tb_mem_arbiter;
    localparam int WIDTH = 8;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FILE("")) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: memory contents, preferred requester per port, expected read result.
    logic [WIDTH-1:0] m_mem [DEPTH];
    int               m_rpref = 0;
    int               m_wpref = 0;
    logic [1:0]       e_valid = 2'b00;
    logic [WIDTH-1:0] e_data  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Which requester index wins, or -1 for none.
    function automatic int winner(input logic [1:0] req, input int pref);
        if (req == 2'b11) return pref;
        if (req == 2'b01) return 0;
        if (req == 2'b10) return 1;
        return -1;
    endfunction

    // One clock: drive, check combinational grants and the registered read result, advance model.
    task automatic cycle(
        input  logic             rst,
        input  logic [1:0]       rr,  input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
        input  logic [1:0]       wr,  input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
        input  logic [WIDTH-1:0] wd0, input logic [WIDTH-1:0] wd1,
        output logic [1:0]       og_r, output logic [1:0] og_w,
        output logic [1:0]       ov,   output logic [WIDTH-1:0] od
    );
        int               rw, ww;
        logic [1:0]       xr, xw, n_valid;
        logic [WIDTH-1:0] n_data;
        logic [AW-1:0]    ra, wa;
        logic [WIDTH-1:0] wd;
        reset        = rst;
        bus.rd_req   = rr;
        bus.rd_addr  = {ra1, ra0};
        bus.wr_req   = wr;
        bus.wr_addr  = {wa1, wa0};
        bus.wr_data  = {wd1, wd0};
        #1;
        rw = rst ? -1 : winner(rr, m_rpref);
        ww = rst ? -1 : winner(wr, m_wpref);
        xr = (rw < 0) ? 2'b00 : (rw == 0 ? 2'b01 : 2'b10);
        xw = (ww < 0) ? 2'b00 : (ww == 0 ? 2'b01 : 2'b10);
        og_r = bus.rd_gnt;
        og_w = bus.wr_gnt;
        ov   = bus.rd_valid;
        od   = bus.rd_data;
        chk("rd_gnt", {30'd0, og_r}, {30'd0, xr});
        chk("wr_gnt", {30'd0, og_w}, {30'd0, xw});
        chk("rd_valid", {30'd0, ov}, {30'd0, e_valid});
        if (e_valid != 2'b00) chk("rd_data", {24'd0, od}, {24'd0, e_data});

        ra = (rw == 1) ? ra1 : ra0;
        wa = (ww == 1) ? wa1 : wa0;
        wd = (ww == 1) ? wd1 : wd0;
        n_valid = xr;
        n_data  = e_data;
        if (rw >= 0) begin
            n_data = m_mem[ra];
`ifdef MEM_ARB_BYPASS_EN
            if (ww >= 0 && ra == wa) n_data = wd;
`endif
        end
        if (ww >= 0) m_mem[wa] = wd;
        if (rw >= 0) m_rpref = 1 - rw;
        if (ww >= 0) m_wpref = 1 - ww;
        if (rst) begin
            m_rpref = 0;
            m_wpref = 0;
            n_valid = 2'b00;
        end
        @(posedge clock);
        e_valid = n_valid;
        e_data  = n_data;
        #1;
    endtask

    task automatic idle(output logic [1:0] ov, output logic [WIDTH-1:0] od);
        logic [1:0] gr, gw;
        cycle(1'b0, 2'b00, '0, '0, 2'b00, '0, '0, '0, '0, gr, gw, ov, od);
    endtask

    initial begin
        logic [1:0]       gr, gw, ov;
        logic [WIDTH-1:0] od;
        bus.rd_req  = '0; bus.rd_addr = '0;
        bus.wr_req  = '0; bus.wr_addr = '0; bus.wr_data = '0;
        @(posedge clock); #1;

        // Reset with everything requesting: no grants, valid cleared.
        cycle(1'b1, 2'b11, 6'd1, 6'd2, 2'b11, 6'd1, 6'd2, 8'hFF, 8'hEE, gr, gw, ov, od);
        cycle(1'b1, 2'b11, 6'd1, 6'd2, 2'b11, 6'd1, 6'd2, 8'hFF, 8'hEE, gr, gw, ov, od);
        chk("reset_rd_gnt", {30'd0, gr}, 32'd0);
        chk("reset_wr_gnt", {30'd0, gw}, 32'd0);
        idle(ov, od);
        chk("reset_rd_valid", {30'd0, ov}, 32'd0);

        // Fill the RAM so every later read has a known value.
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b0, 2'b00, '0, '0, 2'b01, AW'(i), '0, WIDTH'($urandom), '0, gr, gw, ov, od);
        m_mem[9] = m_mem[9];

        // Both readers contend: 01, 10, 01, each result one cycle later.
        cycle(1'b1, 2'b00, '0, '0, 2'b00, '0, '0, '0, '0, gr, gw, ov, od);
        cycle(1'b0, 2'b11, 6'd3, 6'd5, 2'b00, '0, '0, '0, '0, gr, gw, ov, od);
        chk("rr_g0", {30'd0, gr}, 32'd1);
        cycle(1'b0, 2'b11, 6'd3, 6'd5, 2'b00, '0, '0, '0, '0, gr, gw, ov, od);
        chk("rr_g1", {30'd0, gr}, 32'd2);
        chk("rr_v0", {30'd0, ov}, 32'd1);
        cycle(1'b0, 2'b11, 6'd3, 6'd5, 2'b00, '0, '0, '0, '0, gr, gw, ov, od);
        chk("rr_g2", {30'd0, gr}, 32'd1);
        chk("rr_v1", {30'd0, ov}, 32'd2);
        idle(ov, od);
        chk("rr_v2", {30'd0, ov}, 32'd1);

        // Write then read back through the other requester.
        cycle(1'b0, 2'b00, '0, '0, 2'b10, '0, 6'd7, '0, 8'hA5, gr, gw, ov, od);
        cycle(1'b0, 2'b01, 6'd7, '0, 2'b00, '0, '0, '0, '0, gr, gw, ov, od);
        idle(ov, od);
        chk("wr_rd_valid", {30'd0, ov}, 32'd1);
        chk("wr_rd_data", {24'd0, od}, 32'hA5);

        // Same-cycle read and write of one address.
        cycle(1'b0, 2'b00, '0, '0, 2'b01, 6'd9, '0, 8'h11, '0, gr, gw, ov, od);
        cycle(1'b0, 2'b01, 6'd9, '0, 2'b01, 6'd9, '0, 8'h3C, '0, gr, gw, ov, od);
        idle(ov, od);
`ifdef MEM_ARB_BYPASS_EN
        chk("collide_data", {24'd0, od}, 32'h3C);
`else
        chk("collide_data", {24'd0, od}, 32'h11);
`endif

        // Contending writers alternate starting from requester 0.
        cycle(1'b1, 2'b00, '0, '0, 2'b00, '0, '0, '0, '0, gr, gw, ov, od);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 2'b00, '0, '0, 2'b11, 6'd20, 6'd21, 8'h5A, 8'hC3, gr, gw, ov, od);
            chk("wr_alt", {30'd0, gw}, (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        cycle(1'b0, 2'b01, 6'd20, '0, 2'b00, '0, '0, '0, '0, gr, gw, ov, od);
        cycle(1'b0, 2'b10, '0, 6'd21, 2'b00, '0, '0, '0, '0, gr, gw, ov, od);
        chk("wr_alt_rb0", {24'd0, od}, 32'h5A);
        idle(ov, od);
        chk("wr_alt_rb1", {24'd0, od}, 32'hC3);

        // Read granted, then reset the next cycle: result dropped, pointer back to 0.
        cycle(1'b0, 2'b01, 6'd20, '0, 2'b00, '0, '0, '0, '0, gr, gw, ov, od);
        cycle(1'b1, 2'b00, '0, '0, 2'b00, '0, '0, '0, '0, gr, gw, ov, od);
        idle(ov, od);
        chk("rst_drop_valid", {30'd0, ov}, 32'd0);

        // Lone requester 1 with pointer at 0 wins; pointer then still favours 0.
        cycle(1'b0, 2'b10, '0, 6'd21, 2'b00, '0, '0, '0, '0, gr, gw, ov, od);
        chk("lone1_gnt", {30'd0, gr}, 32'd2);
        cycle(1'b0, 2'b11, 6'd20, 6'd21, 2'b00, '0, '0, '0, '0, gr, gw, ov, od);
        chk("lone1_next", {30'd0, gr}, 32'd1);
        chk("lone1_data", {24'd0, od}, 32'hC3);

        // Random traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 63) == 0),
                  2'($urandom), AW'($urandom), AW'($urandom),
                  2'($urandom), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                  WIDTH'($urandom), WIDTH'($urandom),
                  gr, gw, ov, od);
        end
        idle(ov, od);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
